hazard5_muldiv_seq: RTL and testbench



---
 rtl/hazard5_muldiv_seq.sv | 154 +++++++++++++++
 tb/tb_hazard5_muldiv_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard5_muldiv_seq.sv
// Iterative RISC-V M-extension multiply/divide unit: magnitudes are iterated
// UNROLL steps per clock, then sign-corrected and presented with a one-cycle valid.
module hazard5_muldiv_seq #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_vld,
  output logic            op_rdy,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            op_kill,
  output logic [XLEN-1:0] result,
  output logic            result_vld
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                div0_q, div0_d;
  logic [XLEN-1:0]     addend_q, addend_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                result_vld_q, result_vld_d;

  logic                signed_a_in, signed_b_in, sign_a_in, sign_b_in;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [2*XLEN-1:0]   acc_step;
  logic [XLEN:0]       sum_w, trial_w;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix;

  // MULHU, DIVU and REMU are fully unsigned; MULHSU treats only op_a as signed.
  assign signed_a_in = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign signed_b_in = signed_a_in && (op != 3'b010);
  assign sign_a_in   = signed_a_in && op_a[XLEN-1];
  assign sign_b_in   = signed_b_in && op_b[XLEN-1];
  assign a_mag       = sign_a_in ? -op_a : op_a;
  assign b_mag       = sign_b_in ? -op_b : op_b;

  assign op_rdy     = (state_q == IDLE) && !rst;
  assign result     = result_q;
  assign result_vld = result_vld_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    div0_d       = div0_q;
    addend_d     = addend_q;
    acc_d        = acc_q;
    count_d      = count_q;
    result_d     = result_q;
    result_vld_d = 1'b0;
    acc_step     = acc_q;
    sum_w        = '0;
    trial_w      = '0;

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = ((sign_a_q ^ sign_b_q) && !div0_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    case (state_q)
      IDLE: begin
        if (op_vld) begin
          op_d     = op;
          sign_a_d = sign_a_in;
          sign_b_d = sign_b_in;
          div0_d   = (op_b == '0);
          // Multiply: low half holds the multiplier; divide: low half holds the dividend.
          addend_d = op[2] ? b_mag : a_mag;
          acc_d    = {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
          count_d  = CNT_INIT;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < UNROLL; i++) begin
          if (op_q[2]) begin
            trial_w = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]} - {1'b0, addend_q};
            if (!trial_w[XLEN])
              acc_step = {trial_w[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
            else
              acc_step = {acc_step[2*XLEN-2:0], 1'b0};
          end else begin
            sum_w    = {1'b0, acc_step[2*XLEN-1:XLEN]} +
                       {1'b0, (acc_step[0] ? addend_q : {XLEN{1'b0}})};
            acc_step = {sum_w, acc_step[XLEN-1:1]};
          end
        end
        acc_d   = acc_step;
        count_d = count_q - CW'(1);
        if (count_q == '0)
          state_d = FIX;
        if (op_kill)
          state_d = IDLE;
      end
      FIX: begin
        if (op_kill) begin
          state_d = IDLE;
        end else begin
          case (op_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quot_fix;
            default:                result_d = rem_fix;
          endcase
          result_vld_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      div0_q       <= 1'b0;
      addend_q     <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      div0_q       <= div0_d;
      addend_q     <= addend_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
    end
  end

endmodule

// File: tb/tb_hazard5_muldiv_seq.sv
// Bench for hazard5_muldiv_seq: four instances (UNROLL 1, 2, 4, 32) share stimulus
// and are checked cycle by cycle against a plain-arithmetic M-extension model.
module tb_hazard5_muldiv_seq;

  localparam int XLEN = 32;
  localparam int ND   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            op_vld;
  logic            op_kill;
  logic [2:0]      op;
  logic [XLEN-1:0] op_a, op_b;
  logic [ND-1:0]   rdy, vld;
  logic [XLEN-1:0] res [ND];

  int total = 0;
  int bad   = 0;

  function automatic int unr(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic int iters(input int k);
    return XLEN / unr(k);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      localparam int U = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 32;
      hazard5_muldiv_seq #(.XLEN(XLEN), .UNROLL(U)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .op_vld     (op_vld),
        .op_rdy     (rdy[gi]),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_kill    (op_kill),
        .result     (res[gi]),
        .result_vld (vld[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p, ua64, ub64;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'b0, b});
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = ua64 * ub64;  return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb);
        return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb);
        return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (rdy !== {ND{1'b1}} && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (rdy !== {ND{1'b1}}) begin
      bad++;
      $display("FAIL idle_timeout rdy got %b want %b", rdy, {ND{1'b1}});
    end
  endtask

  // mode: 0 plain, 1 kill 10 cycles into RUN, 2 reset 10 cycles into RUN,
  //       3 op_kill held high during the accept cycle (must be ignored in IDLE)
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input string name);
    logic [31:0] exp;
    logic        exp_v, exp_r, killed;
    int          n;
    exp = ref_model(f, a, b);
    wait_idle();
    @(negedge clk);
    op_vld = 1'b1; op = f; op_a = a; op_b = b; op_kill = (mode == 3);
    @(posedge clk); #1;
    op_vld = 1'b0; op_kill = 1'b0;
    op = 3'($urandom); op_a = $urandom; op_b = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) begin
        n      = iters(k);
        killed = (mode == 1 || mode == 2) && (n >= 9);
        exp_v  = !killed && (c == n + 1);
        if (mode == 2 && c == 11) exp_r = 1'b0;
        else if (killed)          exp_r = (c >= 11);
        else                      exp_r = (c >= n + 2);
        total++;
        if (vld[k] !== exp_v) begin
          bad++;
          $display("FAIL %s_vld u%0d cyc%0d got %b want %b", name, unr(k), c, vld[k], exp_v);
        end
        total++;
        if (rdy[k] !== exp_r) begin
          bad++;
          $display("FAIL %s_rdy u%0d cyc%0d got %b want %b", name, unr(k), c, rdy[k], exp_r);
        end
        if (exp_v) begin
          total++;
          if (res[k] !== exp) begin
            bad++;
            $display("FAIL %s_result u%0d got %h want %h", name, unr(k), res[k], exp);
          end
        end
      end
      if (mode == 1 && c == 10) op_kill = 1'b1;
      if (mode == 2 && c == 10) rst = 1'b1;
      if (c == 11) begin
        op_kill = 1'b0;
        rst     = 1'b0;
      end
    end
    if (mode == 2) begin
      for (int k = 0; k < ND; k++) begin
        total++;
        if (res[k] !== 32'd0) begin
          bad++;
          $display("FAIL %s_reset_result u%0d got %h want %h", name, unr(k), res[k], 32'd0);
        end
      end
    end
    $display("op %-12s f=%0d a=%h b=%h mode=%0d expect=%h", name, f, a, b, mode, exp);
  endtask

  task automatic test_reset();
    rst = 1'b1; op_vld = 1'b0; op_kill = 1'b0; op = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rdy !== '0 || vld !== '0) begin
      bad++;
      $display("FAIL reset_flags rdy/vld got %b/%b want 0/0", rdy, vld);
    end
    for (int k = 0; k < ND; k++) begin
      total++;
      if (res[k] !== 32'd0) begin
        bad++;
        $display("FAIL reset_result u%0d got %h want %h", unr(k), res[k], 32'd0);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rdy !== {ND{1'b1}}) begin
      bad++;
      $display("FAIL reset_release rdy got %b want %b", rdy, {ND{1'b1}});
    end
    $display("reset checked");
  endtask

  task automatic test_multiply();
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0007, 0, "mul_neg");
  endtask

  task automatic test_divide();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,   0, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,   0, "rem_neg");
    run_op(3'd5, 32'd100,       32'd7,   0, "divu");
    run_op(3'd7, 32'd100,       32'd7,   0, "remu");
  endtask

  task automatic test_corners();
    run_op(3'd5, 32'd5,         32'd0,         0, "divu_zero");
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0,         0, "div_zero");
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0,         0, "rem_zero");
    run_op(3'd7, 32'h1234_5678, 32'd0,         0, "remu_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
  endtask

  task automatic test_abort();
    run_op(3'd0, 32'h0001_2345, 32'h0000_0678, 1, "kill_run");
    run_op(3'd5, 32'd9, 32'd3, 0, "after_kill");
    run_op(3'd4, 32'hFFFF_FF00, 32'd5, 2, "reset_run");
    run_op(3'd5, 32'd9, 32'd3, 0, "after_reset");
    run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0001, 3, "kill_idle");
  endtask

  // op_vld held high: each instance re-accepts N+3 edges after its previous accept.
  task automatic test_back_to_back();
    logic [31:0] exp;
    logic        exp_v;
    int          n;
    exp = ref_model(3'd4, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    @(negedge clk);
    op_vld = 1'b1; op = 3'd4; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    @(posedge clk); #1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) begin
        n     = iters(k);
        exp_v = (c >= n + 1) && (((c - n - 1) % (n + 3)) == 0);
        total++;
        if (vld[k] !== exp_v) begin
          bad++;
          $display("FAIL b2b_vld u%0d cyc%0d got %b want %b", unr(k), c, vld[k], exp_v);
        end
        if (exp_v) begin
          total++;
          if (res[k] !== exp) begin
            bad++;
            $display("FAIL b2b_result u%0d cyc%0d got %h want %h", unr(k), c, res[k], exp);
          end
        end
      end
    end
    op_vld = 1'b0;
    $display("op back_to_back f=4 a=fffffff9 b=00000002 expect=%h", exp);
    wait_idle();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int t = 0; t < 40; t++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(f, a, b, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_corners();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
